// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with one write port, two
// registered read ports, per-register "written since reset" flags, an
// optional hardwired-zero register 0 and a global stall input.
//
// Ports:
//   CLK        - clock, all state updates on the rising edge
//   reset      - asynchronous active-high reset
//   WRITE      - write enable
//   INaddr     - write address
//   IN         - write data
//   OUT1addr   - read port 1 address
//   OUT2addr   - read port 2 address
//   busy_wait  - stall: freezes registers, flags and outputs while high
//   OUT1/OUT2  - registered read data (1-cycle latency, write-first bypass)
//   OUT1_valid - addressed register on port 1 written since reset (registered)
//   OUT2_valid - same for port 2
module regfile_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] INaddr,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] OUT1addr,
    input  logic [ADDR_W-1:0] OUT2addr,
    input  logic              busy_wait,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              OUT1_valid,
    output logic              OUT2_valid
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned N_PORTS = 2;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  flags_q;
    logic [DEPTH-1:0]  flags_d;

    logic [ADDR_W-1:0] rd_addr [N_PORTS];
    logic [DATA_W-1:0] out_q   [N_PORTS];
    logic [DATA_W-1:0] out_d   [N_PORTS];
    logic              vld_q   [N_PORTS];
    logic              vld_d   [N_PORTS];

    logic              wr_accept;

    assign rd_addr[0] = OUT1addr;
    assign rd_addr[1] = OUT2addr;

    // A write to the hardwired-zero register is dropped entirely.
    assign wr_accept = WRITE && !(ZERO_REG && (INaddr == '0));

    // Next state for the array, flags and both read ports (write-first).
    always_comb begin
        regs_d  = regs_q;
        flags_d = flags_q;
        for (int p = 0; p < N_PORTS; p++) begin
            out_d[p] = '0;
            vld_d[p] = 1'b0;
        end

        if (wr_accept) begin
            regs_d[INaddr]  = IN;
            flags_d[INaddr] = 1'b1;
        end

        for (int p = 0; p < N_PORTS; p++) begin
            if (ZERO_REG && (rd_addr[p] == '0)) begin
                out_d[p] = '0;
                vld_d[p] = 1'b1;
            end else if (wr_accept && (INaddr == rd_addr[p])) begin
                out_d[p] = IN;
                vld_d[p] = 1'b1;
            end else begin
                out_d[p] = regs_q[rd_addr[p]];
                vld_d[p] = flags_q[rd_addr[p]];
            end
        end
    end

    // State update; busy_wait holds everything, reset overrides both.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= '0;
            for (int p = 0; p < N_PORTS; p++) begin
                out_q[p] <= '0;
                vld_q[p] <= 1'b0;
            end
        end else if (!busy_wait) begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
            for (int p = 0; p < N_PORTS; p++) begin
                out_q[p] <= out_d[p];
                vld_q[p] <= vld_d[p];
            end
        end
    end

    assign OUT1       = out_q[0];
    assign OUT2       = out_q[1];
    assign OUT1_valid = vld_q[0];
    assign OUT2_valid = vld_q[1];

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed bench for regfile_param. Three instances:
// a (8/3, no zero reg), b (8/3, zero reg), c (16/4, no zero reg).
module tb_regfile_param;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance a
    logic       a_write, a_busy;
    logic [2:0] a_inaddr, a_o1addr, a_o2addr;
    logic [7:0] a_in, a_out1, a_out2;
    logic       a_v1, a_v2;
    // Instance b
    logic       b_write, b_busy;
    logic [2:0] b_inaddr, b_o1addr, b_o2addr;
    logic [7:0] b_in, b_out1, b_out2;
    logic       b_v1, b_v2;
    // Instance c
    logic        c_write, c_busy;
    logic [3:0]  c_inaddr, c_o1addr, c_o2addr;
    logic [15:0] c_in, c_out1, c_out2;
    logic        c_v1, c_v2;

    regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0)) u_a (
        .CLK(CLK), .reset(reset), .WRITE(a_write), .INaddr(a_inaddr), .IN(a_in),
        .OUT1addr(a_o1addr), .OUT2addr(a_o2addr), .busy_wait(a_busy),
        .OUT1(a_out1), .OUT2(a_out2), .OUT1_valid(a_v1), .OUT2_valid(a_v2));

    regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) u_b (
        .CLK(CLK), .reset(reset), .WRITE(b_write), .INaddr(b_inaddr), .IN(b_in),
        .OUT1addr(b_o1addr), .OUT2addr(b_o2addr), .busy_wait(b_busy),
        .OUT1(b_out1), .OUT2(b_out2), .OUT1_valid(b_v1), .OUT2_valid(b_v2));

    regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0)) u_c (
        .CLK(CLK), .reset(reset), .WRITE(c_write), .INaddr(c_inaddr), .IN(c_in),
        .OUT1addr(c_o1addr), .OUT2addr(c_o2addr), .busy_wait(c_busy),
        .OUT1(c_out1), .OUT2(c_out2), .OUT1_valid(c_v1), .OUT2_valid(c_v2));

    // Advance one rising edge; inputs are driven and outputs sampled 1 after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        // Reset rises before the first clock edge: outputs must clear asynchronously.
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (a_out1 !== 8'd0 || a_out2 !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %0d/%0d expected 0/0", a_out1, a_out2);
        end
        n_cmp++;
        if (a_v1 !== 1'b0 || a_v2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b/%b expected 0/0", a_v1, a_v2);
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        a_write = 1'b1; a_inaddr = 3'd2; a_in = 8'd200;
        tick();
        a_inaddr = 3'd4; a_in = 8'd100;
        tick();
        // Ports still address reg 0, never written.
        n_cmp++;
        if (a_out1 !== 8'd0 || a_v1 !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_unwritten0: got %0d v%b expected 0 v0", a_out1, a_v1);
        end
        a_write = 1'b0; a_o1addr = 3'd2; a_o2addr = 3'd4;
        // Addresses just applied: outputs not yet updated (1-cycle latency).
        n_cmp++;
        if (a_out1 !== 8'd0) begin
            n_bad++;
            $display("FAIL rd_latency: got %0d expected 0", a_out1);
        end
        tick();
        n_cmp++;
        if (a_out1 !== 8'd200 || a_v1 !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_reg2: got %0d v%b expected 200 v1", a_out1, a_v1);
        end
        n_cmp++;
        if (a_out2 !== 8'd100 || a_v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_reg4: got %0d v%b expected 100 v1", a_out2, a_v2);
        end
    endtask

    task automatic test_bypass();
        a_o1addr = 3'd5;
        tick();
        n_cmp++;
        if (a_out1 !== 8'd0 || a_v1 !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_reg5_unwritten: got %0d v%b expected 0 v0", a_out1, a_v1);
        end
        a_write = 1'b1; a_inaddr = 3'd5; a_in = 8'd7;
        tick();
        a_write = 1'b0;
        n_cmp++;
        if (a_out1 !== 8'd7 || a_v1 !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass_reg5: got %0d v%b expected 7 v1", a_out1, a_v1);
        end
        n_cmp++;
        if (a_out2 !== 8'd100 || a_v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass_other_port: got %0d v%b expected 100 v1", a_out2, a_v2);
        end
    endtask

    task automatic test_stall();
        a_o1addr = 3'd3; a_o2addr = 3'd2;
        tick();
        n_cmp++;
        if (a_out1 !== 8'd0 || a_v1 !== 1'b0 || a_out2 !== 8'd200) begin
            n_bad++;
            $display("FAIL stall_pre: got %0d v%b / %0d expected 0 v0 / 200", a_out1, a_v1, a_out2);
        end
        a_busy = 1'b1; a_write = 1'b1; a_inaddr = 3'd3; a_in = 8'd55;
        a_o1addr = 3'd3; a_o2addr = 3'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (a_out1 !== 8'd0 || a_v1 !== 1'b0 || a_out2 !== 8'd200 || a_v2 !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_frozen[%0d]: got %0d v%b / %0d v%b expected 0 v0 / 200 v1",
                         i, a_out1, a_v1, a_out2, a_v2);
            end
        end
        a_busy = 1'b0;
        tick();
        n_cmp++;
        if (a_out1 !== 8'd55 || a_v1 !== 1'b1 || a_out2 !== 8'd100) begin
            n_bad++;
            $display("FAIL stall_release: got %0d v%b / %0d expected 55 v1 / 100", a_out1, a_v1, a_out2);
        end
        a_write = 1'b0; a_o2addr = 3'd3;
        tick();
        n_cmp++;
        if (a_out2 !== 8'd55 || a_v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_committed: got %0d v%b expected 55 v1", a_out2, a_v2);
        end
    endtask

    task automatic test_async_reset();
        a_write = 1'b1; a_inaddr = 3'd2; a_in = 8'd33; a_o1addr = 3'd2; a_o2addr = 3'd5;
        tick();
        a_write = 1'b0;
        n_cmp++;
        if (a_out1 !== 8'd33 || a_out2 !== 8'd7) begin
            n_bad++;
            $display("FAIL pre_async_reset: got %0d / %0d expected 33 / 7", a_out1, a_out2);
        end
        // Mid-cycle reset: no clock edge between assertion and the check.
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (a_out1 !== 8'd0 || a_out2 !== 8'd0 || a_v1 !== 1'b0 || a_v2 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %0d v%b / %0d v%b expected 0 v0 / 0 v0",
                     a_out1, a_v1, a_out2, a_v2);
        end
        // A write presented while in reset must be discarded.
        a_write = 1'b1; a_inaddr = 3'd2; a_in = 8'd77;
        tick();
        a_write = 1'b0;
        reset = 1'b0;
        tick();
        n_cmp++;
        if (a_out1 !== 8'd0 || a_v1 !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_reg2: got %0d v%b expected 0 v0", a_out1, a_v1);
        end
        n_cmp++;
        if (a_out2 !== 8'd0 || a_v2 !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_reg5: got %0d v%b expected 0 v0", a_out2, a_v2);
        end
    endtask

    task automatic test_zero_reg();
        b_write = 1'b1; b_inaddr = 3'd0; b_in = 8'd99; b_o1addr = 3'd0; b_o2addr = 3'd0;
        tick();
        n_cmp++;
        if (b_out1 !== 8'd0 || b_v1 !== 1'b1 || b_out2 !== 8'd0 || b_v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_reg_write: got %0d v%b / %0d v%b expected 0 v1 / 0 v1",
                     b_out1, b_v1, b_out2, b_v2);
        end
        b_inaddr = 3'd6; b_in = 8'd12;
        tick();
        b_write = 1'b0; b_o1addr = 3'd6; b_o2addr = 3'd6;
        tick();
        n_cmp++;
        if (b_out1 !== 8'd12 || b_v1 !== 1'b1 || b_out2 !== 8'd12 || b_v2 !== 1'b1) begin
            n_bad++;
            $display("FAIL dual_port_reg6: got %0d v%b / %0d v%b expected 12 v1 / 12 v1",
                     b_out1, b_v1, b_out2, b_v2);
        end
        b_o1addr = 3'd0; b_o2addr = 3'd1;
        tick();
        n_cmp++;
        if (b_out1 !== 8'd0 || b_v1 !== 1'b1 || b_out2 !== 8'd0 || b_v2 !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_reg_held: got %0d v%b / %0d v%b expected 0 v1 / 0 v0",
                     b_out1, b_v1, b_out2, b_v2);
        end
    endtask

    task automatic test_wide();
        c_write = 1'b1; c_inaddr = 4'd15; c_in = 16'hBEEF;
        tick();
        c_write = 1'b0; c_o2addr = 4'd15;
        for (int i = 0; i < 15; i++) begin
            c_o1addr = 4'(i);
            tick();
            n_cmp++;
            if (c_out1 !== 16'h0 || c_v1 !== 1'b0 || c_out2 !== 16'hBEEF || c_v2 !== 1'b1) begin
                n_bad++;
                $display("FAIL wide_reg%0d: got %h v%b / %h v%b expected 0000 v0 / beef v1",
                         i, c_out1, c_v1, c_out2, c_v2);
            end
        end
    endtask

    initial begin
        a_write = 1'b0; a_busy = 1'b0; a_inaddr = '0; a_o1addr = '0; a_o2addr = '0; a_in = '0;
        b_write = 1'b0; b_busy = 1'b0; b_inaddr = '0; b_o1addr = '0; b_o2addr = '0; b_in = '0;
        c_write = 1'b0; c_busy = 1'b0; c_inaddr = '0; c_o1addr = '0; c_o2addr = '0; c_in = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_async_reset();
        test_zero_reg();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
